// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with enable, parallel load, prescaler,
// wrap or saturate at the limits, and a one-cycle terminal-count pulse.
module bcd_counter_n #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0,
    parameter int PRESCALE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  tc,
    output logic                  at_limit
);

    localparam int              W         = 4 * DIGITS;
    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [W-1:0]    ALL_NINES = {DIGITS{4'd9}};

    logic [W-1:0]  digits_q, digits_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tc_q, tc_d;
    logic          at_limit_q, at_limit_d;

    logic [W-1:0]  incr, decr, clamped;
    logic          all_nines, all_zeros, step;
    logic          carry, borrow;

    // Ripple carry/borrow across the digits; a 9 rolls to 0 going up and a 0
    // rolls to 9 going down, so no binary-to-decimal conversion is needed.
    always_comb begin
        carry     = 1'b1;
        borrow    = 1'b1;
        incr      = '0;
        decr      = '0;
        all_nines = 1'b1;
        all_zeros = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (digits_q[4*k +: 4] != 4'd9) all_nines = 1'b0;
            if (digits_q[4*k +: 4] != 4'd0) all_zeros = 1'b0;

            if (!carry) begin
                incr[4*k +: 4] = digits_q[4*k +: 4];
            end else if (digits_q[4*k +: 4] == 4'd9) begin
                incr[4*k +: 4] = 4'd0;
            end else begin
                incr[4*k +: 4] = digits_q[4*k +: 4] + 4'd1;
                carry          = 1'b0;
            end

            if (!borrow) begin
                decr[4*k +: 4] = digits_q[4*k +: 4];
            end else if (digits_q[4*k +: 4] == 4'd0) begin
                decr[4*k +: 4] = 4'd9;
            end else begin
                decr[4*k +: 4] = digits_q[4*k +: 4] - 4'd1;
                borrow         = 1'b0;
            end
        end
    end

    always_comb begin
        clamped = '0;
        for (int k = 0; k < DIGITS; k++) begin
            clamped[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        digits_d = digits_q;
        pcnt_d   = pcnt_q;
        tc_d     = 1'b0;
        step     = 1'b0;

        if (load) begin
            digits_d = clamped;
            pcnt_d   = '0;
        end else if (en) begin
            if (pcnt_q == PCNT_LAST) begin
                step   = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end

            if (step) begin
                if (up) begin
                    if (all_nines) begin
                        tc_d     = 1'b1;
                        digits_d = SATURATE ? digits_q : '0;
                    end else begin
                        digits_d = incr;
                    end
                end else begin
                    if (all_zeros) begin
                        tc_d     = 1'b1;
                        digits_d = SATURATE ? digits_q : ALL_NINES;
                    end else begin
                        digits_d = decr;
                    end
                end
            end
        end

        at_limit_d = up ? (digits_d == ALL_NINES) : (digits_d == '0);
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q   <= '0;
            pcnt_q     <= '0;
            tc_q       <= 1'b0;
            // A zero count sits on the lower limit when counting down.
            at_limit_q <= ~up;
        end else begin
            digits_q   <= digits_d;
            pcnt_q     <= pcnt_d;
            tc_q       <= tc_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign digits   = digits_q;
    assign tc       = tc_q;
    assign at_limit = at_limit_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: three instances cover wrap, saturate and
// prescaled configurations from shared stimulus.
module tb_bcd_counter_n;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;

    logic [15:0] a_digits, s_digits, p_digits;
    logic        a_tc, s_tc, p_tc;
    logic        a_lim, s_lim, p_lim;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0), .PRESCALE(1)) dut_a (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .digits(a_digits), .tc(a_tc), .at_limit(a_lim)
    );

    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1), .PRESCALE(1)) dut_s (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .digits(s_digits), .tc(s_tc), .at_limit(s_lim)
    );

    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0), .PRESCALE(5)) dut_p (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .digits(p_digits), .tc(p_tc), .at_limit(p_lim)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1; up = 1'b1; en = 1'b1; load = 1'b0;
        tick();
        tick();
        checks++;
        if (a_digits !== 16'h0000 || s_digits !== 16'h0000 || p_digits !== 16'h0000) begin
            errors++;
            $display("FAIL reset digits: got %h/%h/%h want 0000", a_digits, s_digits, p_digits);
        end
        checks++;
        if ({a_tc, s_tc, p_tc} !== 3'b000) begin
            errors++;
            $display("FAIL reset tc: got %b%b%b want 000", a_tc, s_tc, p_tc);
        end
        checks++;
        if ({a_lim, s_lim, p_lim} !== 3'b000) begin
            errors++;
            $display("FAIL reset at_limit: got %b%b%b want 000", a_lim, s_lim, p_lim);
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap_walk();
        int tc_seen;
        tc_seen = 0;
        en = 1'b1; up = 1'b1; load = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            if (a_tc === 1'b1) tc_seen++;
            checks++;
            if (a_digits !== to_bcd(k % 10000)) begin
                errors++;
                $display("FAIL walk digits tick %0d: got %h want %h", k, a_digits, to_bcd(k % 10000));
            end
            checks++;
            if (a_tc !== (k == 10000)) begin
                errors++;
                $display("FAIL walk tc tick %0d: got %b want %b", k, a_tc, (k == 10000));
            end
            checks++;
            if (a_lim !== ((k % 10000) == 9999)) begin
                errors++;
                $display("FAIL walk at_limit tick %0d: got %b want %b", k, a_lim, ((k % 10000) == 9999));
            end
        end
        checks++;
        if (tc_seen != 1) begin
            errors++;
            $display("FAIL walk tc count: got %0d want 1", tc_seen);
        end
        en = 1'b0;
    endtask

    task automatic test_carry_load();
        logic [15:0] exp [3] = '{16'h0199, 16'h0200, 16'h0201};
        load = 1'b1; load_val = 16'h0199; en = 1'b0; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (a_digits !== exp[i] || s_digits !== exp[i]) begin
                errors++;
                $display("FAIL carry digits step %0d: got %h/%h want %h", i, a_digits, s_digits, exp[i]);
            end
            checks++;
            if (a_tc !== 1'b0 || s_tc !== 1'b0) begin
                errors++;
                $display("FAIL carry tc step %0d: got %b/%b want 0", i, a_tc, s_tc);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_lower_limit();
        load = 1'b1; load_val = 16'h0000; en = 1'b0; up = 1'b0;
        tick();
        checks++;
        if (a_lim !== 1'b1 || s_lim !== 1'b1) begin
            errors++;
            $display("FAIL lower load at_limit: got %b/%b want 1", a_lim, s_lim);
        end
        load = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (a_digits !== 16'h9999 || a_tc !== 1'b1 || a_lim !== 1'b0) begin
            errors++;
            $display("FAIL lower wrap: got %h tc=%b lim=%b want 9999 tc=1 lim=0", a_digits, a_tc, a_lim);
        end
        checks++;
        if (s_digits !== 16'h0000 || s_tc !== 1'b1 || s_lim !== 1'b1) begin
            errors++;
            $display("FAIL lower sat: got %h tc=%b lim=%b want 0000 tc=1 lim=1", s_digits, s_tc, s_lim);
        end
        tick();
        checks++;
        if (s_digits !== 16'h0000 || s_tc !== 1'b1) begin
            errors++;
            $display("FAIL lower sat back_to_back: got %h tc=%b want 0000 tc=1", s_digits, s_tc);
        end
        checks++;
        if (a_digits !== 16'h9998 || a_tc !== 1'b0) begin
            errors++;
            $display("FAIL lower borrow: got %h tc=%b want 9998 tc=0", a_digits, a_tc);
        end
        en = 1'b0;
        tick();
        checks++;
        if (s_tc !== 1'b0 || s_digits !== 16'h0000) begin
            errors++;
            $display("FAIL lower idle: got %h tc=%b want 0000 tc=0", s_digits, s_tc);
        end
    endtask

    task automatic test_upper_saturate();
        load = 1'b1; load_val = 16'h9999; en = 1'b0; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (s_digits !== 16'h9999 || s_tc !== 1'b1 || s_lim !== 1'b1) begin
            errors++;
            $display("FAIL upper sat: got %h tc=%b lim=%b want 9999 tc=1 lim=1", s_digits, s_tc, s_lim);
        end
        checks++;
        if (a_digits !== 16'h0000 || a_tc !== 1'b1) begin
            errors++;
            $display("FAIL upper wrap: got %h tc=%b want 0000 tc=1", a_digits, a_tc);
        end
        tick();
        checks++;
        if (s_digits !== 16'h9999 || s_tc !== 1'b1) begin
            errors++;
            $display("FAIL upper sat back_to_back: got %h tc=%b want 9999 tc=1", s_digits, s_tc);
        end
        checks++;
        if (a_digits !== 16'h0001 || a_tc !== 1'b0) begin
            errors++;
            $display("FAIL upper after wrap: got %h tc=%b want 0001 tc=0", a_digits, a_tc);
        end
        en = 1'b0;
    endtask

    task automatic test_prescaler();
        logic [15:0] exp;
        load = 1'b1; load_val = 16'h0000; en = 1'b0; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k >= 10) ? 16'h0002 : (k >= 5) ? 16'h0001 : 16'h0000;
            checks++;
            if (p_digits !== exp || p_tc !== 1'b0) begin
                errors++;
                $display("FAIL prescale clock %0d: got %h tc=%b want %h tc=0", k, p_digits, p_tc, exp);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (p_digits !== 16'h0002) begin
            errors++;
            $display("FAIL prescale hold: got %h want 0002", p_digits);
        end
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = (k == 3) ? 16'h0003 : 16'h0002;
            checks++;
            if (p_digits !== exp) begin
                errors++;
                $display("FAIL prescale resume %0d: got %h want %h", k, p_digits, exp);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_clamp();
        load = 1'b1; load_val = 16'hA3F1; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (a_digits !== 16'h9391 || p_digits !== 16'h9391) begin
            errors++;
            $display("FAIL clamp: got %h/%h want 9391", a_digits, p_digits);
        end
    endtask

    task automatic test_reset_priority();
        logic [15:0] exp;
        load = 1'b1; load_val = 16'h0457; en = 1'b0; up = 1'b1;
        tick();
        checks++;
        if (p_digits !== 16'h0457) begin
            errors++;
            $display("FAIL rstprio load: got %h want 0457", p_digits);
        end
        load = 1'b0; en = 1'b1;
        tick();
        tick();
        reset = 1'b1; load = 1'b1;
        tick();
        checks++;
        if (p_digits !== 16'h0000 || p_tc !== 1'b0 || p_lim !== 1'b0) begin
            errors++;
            $display("FAIL rstprio reset: got %h tc=%b lim=%b want 0000 tc=0 lim=0", p_digits, p_tc, p_lim);
        end
        reset = 1'b0; load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = (k == 5) ? 16'h0001 : 16'h0000;
            checks++;
            if (p_digits !== exp) begin
                errors++;
                $display("FAIL rstprio step %0d: got %h want %h", k, p_digits, exp);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_walk();
        test_carry_load();
        test_lower_limit();
        test_upper_saturate();
        test_prescaler();
        test_clamp();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
